// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: the VGA scanout read path always wins,
// and the game-logic writer takes the leftover cycles. HS/VS are delayed to match the pixel pipeline.
module vram_arbiter #(
    parameter int COLOR_W     = 8,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               pix_tick,
    input  logic               ativo,
    input  logic [10:0]        sx,
    input  logic [10:0]        sy,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               wr_req,
    input  logic [10:0]        wr_x,
    input  logic [10:0]        wr_y,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_ack,
    output logic               wr_err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid,
    output logic               hs_out,
    output logic               vs_out
);

    localparam logic [10:0] FB_W = 11'(640 >> SCALE_SHIFT);
    localparam logic [10:0] FB_H = 11'(480 >> SCALE_SHIFT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    logic [1:0]        state;
    logic              take_rd;
    logic              take_wr;
    logic              in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              p1_tick;
    logic              p1_act;
    logic              p2_tick;
    logic              p2_act;
    logic [2:0]        hs_sr;
    logic [2:0]        vs_sr;

    // Address math is done at ADDR_W width; modular arithmetic makes this
    // identical to a full-width product truncated afterwards.
    always_comb begin
        take_rd  = pix_tick & ativo;
        take_wr  = ~take_rd & wr_req & (state != WR);
        in_range = (wr_x < FB_W) && (wr_y < FB_H);
        rd_addr  = ADDR_W'(sy >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(sx >> SCALE_SHIFT);
        wr_addr  = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
    end

    // Being in WR is exactly the one-cycle ack; it also blocks re-serving the same request.
    assign wr_ack = (state == WR);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_err    <= 1'b0;
        end else if (take_rd) begin
            state    <= RD;
            mem_addr <= rd_addr;
            mem_we   <= 1'b0;
            wr_err   <= 1'b0;
        end else if (take_wr) begin
            state    <= WR;
            mem_addr <= wr_addr;
            mem_we   <= in_range;
            wr_err   <= ~in_range;
            if (in_range) begin
                mem_wdata <= wr_data;
            end
        end else begin
            state  <= IDLE;
            mem_we <= 1'b0;
            wr_err <= 1'b0;
        end
    end

    // Tick -> address -> RAM data -> pixel; blanking ticks still flow through to force black.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            p1_tick   <= 1'b0;
            p1_act    <= 1'b0;
            p2_tick   <= 1'b0;
            p2_act    <= 1'b0;
            pix_color <= '0;
            pix_valid <= 1'b0;
            hs_sr     <= 3'b111;
            vs_sr     <= 3'b111;
        end else begin
            p1_tick <= pix_tick;
            p1_act  <= pix_tick & ativo;
            p2_tick <= p1_tick;
            p2_act  <= p1_act;
            if (p2_tick) begin
                pix_color <= p2_act ? mem_rdata : '0;
                pix_valid <= p2_act;
            end
            hs_sr <= {hs_sr[1:0], hs_in};
            vs_sr <= {vs_sr[1:0], vs_in};
        end
    end

    assign hs_out = hs_sr[2];
    assign vs_out = vs_sr[2];

endmodule
